// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared types and constants for the monitor channel scanner
package monitor_pkg;

  // Scanner phases: waiting for start, letting the mux output settle, offering a capture.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } scan_state_t;

  // Index into the 16-way monitor mux.
  typedef logic [3:0] ch_t;

  // Width of the completed-frame counter.
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/monitor_scan.sv
// rtl/monitor_scan.sv - steps the monitor mux select, captures each channel and streams it out
module monitor_scan
  import monitor_pkg::*;
#(
  parameter int N          = 8,
  parameter int LAST_CH    = 15,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   abort,
  output logic [3:0]             sel,
  input  logic [N-1:0]           din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_ch,
  output logic [N-1:0]           out_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // The counter only ever holds SETTLE_CYC-1 down to 0.
  localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam ch_t              LAST     = ch_t'(LAST_CH);

  scan_state_t            state_q, state_d;
  ch_t                    idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  ch_t                    out_ch_q, out_ch_d;
  logic [N-1:0]           out_data_q, out_data_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   handshake;

  assign handshake = out_valid_q & out_ready;

  // Next-state logic: abort overrides everything, otherwise walk IDLE -> SETTLE -> SEND per channel.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (abort) begin
      // sel keeps pointing at the aborted channel; only the offer is withdrawn.
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_d   = '0;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end
        end

        SETTLE: begin
          if (cnt_q == '0) begin
            // sel has now been stable for SETTLE_CYC cycles, so din is trustworthy.
            out_data_d  = din;
            out_ch_d    = idx_q;
            out_valid_d = 1'b1;
            state_d     = SEND;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        SEND: begin
          if (handshake) begin
            out_valid_d = 1'b0;
            if (idx_q == LAST) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
              if (continuous) begin
                idx_d   = '0;
                cnt_d   = CNT_LOAD;
                state_d = SETTLE;
              end else begin
                state_d = IDLE;
              end
            end else begin
              idx_d   = idx_q + ch_t'(1);
              cnt_d   = CNT_LOAD;
              state_d = SETTLE;
            end
          end
        end

        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously so a mid-frame reset takes effect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign sel        = idx_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_monitor_scan.sv
// tb/tb_monitor_scan.sv - self-checking bench for monitor_scan
module tb_monitor_scan;

  localparam int S_A    = 2;
  localparam int LAST_A = 15;

  logic       clk;
  logic       rst;

  logic       start_a, cont_a, abort_a, ready_a;
  logic [3:0] sel_a, out_ch_a;
  logic [7:0] din_a, out_data_a, frame_cnt_a;
  logic       out_valid_a, busy_a, frame_done_a;

  logic       start_b, cont_b, abort_b, ready_b;
  logic [3:0] sel_b, out_ch_b;
  logic [7:0] din_b, out_data_b, frame_cnt_b;
  logic       out_valid_b, busy_b, frame_done_b;

  int n_checks;
  int n_fail;
  int cyc;

  // reference model of DUT A, kept in absolute cycle times
  logic       m_busy, m_valid, m_done;
  int         m_ch, m_due, m_frames;
  logic [3:0] m_out_ch;
  logic [7:0] m_out_data;

  assign din_a = 8'hA0 + {4'h0, sel_a};
  assign din_b = 8'h50 + {4'h0, sel_b};

  monitor_scan #(.N(8), .LAST_CH(LAST_A), .SETTLE_CYC(S_A)) u_dut_a (
    .clk(clk), .reset(rst), .start(start_a), .continuous(cont_a), .abort(abort_a),
    .sel(sel_a), .din(din_a), .out_valid(out_valid_a), .out_ready(ready_a),
    .out_ch(out_ch_a), .out_data(out_data_a), .busy(busy_a),
    .frame_done(frame_done_a), .frame_cnt(frame_cnt_a)
  );

  monitor_scan #(.N(8), .LAST_CH(0), .SETTLE_CYC(1)) u_dut_b (
    .clk(clk), .reset(rst), .start(start_b), .continuous(cont_b), .abort(abort_b),
    .sel(sel_b), .din(din_b), .out_valid(out_valid_b), .out_ready(ready_b),
    .out_ch(out_ch_b), .out_data(out_data_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_cnt(frame_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
    m_ch = 0; m_due = 0; m_frames = 0;
    m_out_ch = '0; m_out_data = '0;
  endtask

  // one clock edge of the scanner's behaviour, given the inputs present at that edge
  task automatic model_edge(input logic st, input logic cont, input logic ab, input logic rdy);
    m_done = 1'b0;
    if (ab) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1;
        m_ch   = 0;
        m_due  = cyc + S_A;
      end
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (m_ch == LAST_A) begin
          m_done   = 1'b1;
          m_frames = m_frames + 1;
          if (cont) begin
            m_ch  = 0;
            m_due = cyc + S_A;
          end else begin
            m_busy = 1'b0;
          end
        end else begin
          m_ch  = m_ch + 1;
          m_due = cyc + S_A;
        end
      end
    end else if (cyc == m_due) begin
      m_valid    = 1'b1;
      m_out_ch   = 4'(m_ch);
      m_out_data = 8'hA0 + 8'(m_ch);
    end
  endtask

  task automatic compare_a();
    check("a_valid", 32'(out_valid_a), 32'(m_valid));
    check("a_sel", 32'(sel_a), m_ch);
    check("a_out_ch", 32'(out_ch_a), 32'(m_out_ch));
    check("a_out_data", 32'(out_data_a), 32'(m_out_data));
    check("a_busy", 32'(busy_a), 32'(m_busy));
    check("a_frame_done", 32'(frame_done_a), 32'(m_done));
    check("a_frame_cnt", 32'(frame_cnt_a), m_frames % 256);
  endtask

  task automatic tick();
    logic c_st, c_cont, c_ab, c_rdy, c_rst;
    c_st = start_a; c_cont = cont_a; c_ab = abort_a; c_rdy = ready_a; c_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (c_rst) model_reset();
    else model_edge(c_st, c_cont, c_ab, c_rdy);
    compare_a();
  endtask

  task automatic wait_ch(input int ch, input int budget);
    for (int i = 0; i < budget && !(out_valid_a && out_ch_a == 4'(ch)); i++) tick();
    check("wait_valid_ch", 32'(out_valid_a && out_ch_a == 4'(ch)), 32'd1);
  endtask

  task automatic wait_settle_ch(input int ch, input int budget);
    for (int i = 0; i < budget && !(busy_a && !out_valid_a && sel_a == 4'(ch)); i++) tick();
    check("wait_settle_ch", 32'(busy_a && !out_valid_a && sel_a == 4'(ch)), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy_a; i++) tick();
    check("wait_idle", 32'(busy_a), 32'd0);
  endtask

  task automatic wait_fcnt(input int n, input int budget);
    for (int i = 0; i < budget && frame_cnt_a != 8'(n); i++) tick();
    check("wait_fcnt", 32'(frame_cnt_a), 32'(n));
  endtask

  initial begin
    int t0, first_v, done_t, n_done, n_xfer, f;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    start_a = 0; cont_a = 0; abort_a = 0; ready_a = 0;
    start_b = 0; cont_b = 0; abort_b = 0; ready_b = 0;
    model_reset();
    #2;
    check("reset_a", {18'd0, sel_a, out_valid_a, out_ch_a, out_data_a, busy_a, frame_done_a}, 32'd0);
    check("reset_a_fcnt", 32'(frame_cnt_a), 32'd0);
    check("reset_b", {18'd0, sel_b, out_valid_b, out_ch_b, out_data_b, busy_b, frame_done_b}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single frame, ready tied high
    ready_a = 1; start_a = 1; tick(); start_a = 0; t0 = cyc;
    first_v = -1; done_t = -1; n_done = 0; n_xfer = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid_a && ready_a) n_xfer++;
      tick();
      if (out_valid_a && first_v < 0) first_v = cyc - t0;
      if (frame_done_a) begin done_t = cyc - t0; n_done++; end
    end
    check("first_valid_latency", first_v, 32'd2);
    check("frame_done_cycle", done_t, 32'd48);
    check("frame_done_pulses", n_done, 32'd1);
    check("transfers", n_xfer, 32'd16);
    check("frame_cnt_1", 32'(frame_cnt_a), 32'd1);
    check("busy_after_frame", 32'(busy_a), 32'd0);

    // back-pressure on channel 5
    start_a = 1; tick(); start_a = 0;
    wait_ch(5, 100);
    ready_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", 32'(out_valid_a), 32'd1);
      check("stall_ch", 32'(out_ch_a), 32'd5);
      check("stall_data", 32'(out_data_a), 32'hA5);
      check("stall_sel", 32'(sel_a), 32'd5);
    end
    ready_a = 1; tick();
    check("post_stall_valid", 32'(out_valid_a), 32'd0);
    check("post_stall_sel", 32'(sel_a), 32'd6);
    wait_ch(6, 10);
    check("post_stall_data", 32'(out_data_a), 32'hA6);
    wait_idle(200);
    check("frame_cnt_2", 32'(frame_cnt_a), 32'd2);

    // continuous: three full frames, then drop continuous part way into the fourth
    cont_a = 1; start_a = 1; tick(); start_a = 0;
    wait_fcnt(5, 400);
    for (int i = 0; i < 20; i++) tick();
    cont_a = 0;
    wait_idle(100);
    check("cont_frame_cnt", 32'(frame_cnt_a), 32'd6);

    // abort while settling on channel 7
    start_a = 1; tick(); start_a = 0;
    wait_settle_ch(7, 100);
    f = int'(frame_cnt_a);
    abort_a = 1; tick(); abort_a = 0;
    check("abort_settle_busy", 32'(busy_a), 32'd0);
    check("abort_settle_valid", 32'(out_valid_a), 32'd0);
    check("abort_settle_fcnt", 32'(frame_cnt_a), f);

    // abort while offering channel 3 with ready high
    start_a = 1; tick(); start_a = 0;
    wait_ch(3, 100);
    abort_a = 1; tick(); abort_a = 0;
    check("abort_send_busy", 32'(busy_a), 32'd0);
    check("abort_send_valid", 32'(out_valid_a), 32'd0);
    check("abort_send_sel", 32'(sel_a), 32'd3);

    // abort colliding with the final handshake of a frame
    start_a = 1; tick(); start_a = 0;
    wait_ch(15, 100);
    abort_a = 1; tick(); abort_a = 0;
    check("abort_last_done", 32'(frame_done_a), 32'd0);
    check("abort_last_fcnt", 32'(frame_cnt_a), f);
    tick();
    check("abort_last_done_late", 32'(frame_done_a), 32'd0);

    // start pulses while busy are ignored; then reset during SEND
    start_a = 1; tick();
    for (int i = 0; i < 30; i++) begin
      start_a = 1'($urandom_range(0, 1));
      tick();
    end
    start_a = 0;
    wait_ch(12, 100);
    ready_a = 0;
    tick();
    #1 rst = 1'b1;
    #1;
    check("async_reset_a", {18'd0, sel_a, out_valid_a, out_ch_a, out_data_a, busy_a, frame_done_a}, 32'd0);
    check("async_reset_fcnt", 32'(frame_cnt_a), 32'd0);
    tick(); tick();
    rst = 1'b0; ready_a = 1;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ready_a = ($urandom_range(0, 9) < 7);
      start_a = ($urandom_range(0, 7) == 0);
      abort_a = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) cont_a = ~cont_a;
      tick();
    end
    start_a = 0; abort_a = 0; cont_a = 0; ready_a = 1;
    wait_idle(200);

    // single-channel frames with a one-cycle settle; frame counter wraps
    cont_b = 1; ready_b = 1; start_b = 1; tick(); start_b = 0;
    for (int t = 1; t <= 520; t++) begin
      tick();
      check("b_valid", 32'(out_valid_b), 32'(t % 2));
      check("b_frame_done", 32'(frame_done_b), 32'((t % 2) == 0));
      check("b_frame_cnt", 32'(frame_cnt_b), (t / 2) % 256);
      if (out_valid_b) begin
        check("b_out_ch", 32'(out_ch_b), 32'd0);
        check("b_out_data", 32'(out_data_b), 32'h50);
      end
      if (t == 510) check("b_cnt_255", 32'(frame_cnt_b), 32'd255);
      if (t == 512) check("b_cnt_wrap", 32'(frame_cnt_b), 32'd0);
    end
    cont_b = 0;
    for (int i = 0; i < 4; i++) tick();
    check("b_idle", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
